// File: rtl/sc_scratchpad_pkg.sv
// sc_scratchpad_pkg
//   Shared types and helpers for the scratchpad memory that sits behind the
//   systolic array's sc_* queue bus.
//   - word_t          : 32-bit data/address word
//   - sc_idx_t        : word index into the default-depth storage
//   - sc_rd_req_t     : one lane's read request {valid, x_addr, w_addr}
//   - sc_wr_req_t     : one lane's write request {valid, addr, data}
//   - sc_in_range()   : byte address -> in-range test against base/depth
//   - sc_sat_add()    : saturating 32-bit accumulate
package sc_scratchpad_pkg;

  typedef logic [31:0] word_t;

  localparam int SC_WORD_BYTES  = 4;
  localparam int SC_WORD_SHIFT  = $clog2(SC_WORD_BYTES);
  localparam int SC_DEPTH_WORDS = 4096;

  typedef logic [$clog2(SC_DEPTH_WORDS)-1:0] sc_idx_t;

  typedef struct packed {
    logic  valid;
    word_t x_addr;
    word_t w_addr;
  } sc_rd_req_t;

  typedef struct packed {
    logic  valid;
    word_t addr;
    word_t data;
  } sc_wr_req_t;

  // Byte offset below base wraps to a huge value, so the explicit
  // addr >= base test is what rejects it.
  function automatic logic sc_in_range(input word_t addr, input word_t base,
                                        input word_t depth_words);
    word_t off;
    off = addr - base;
    return (addr >= base) && ((off >> SC_WORD_SHIFT) < depth_words);
  endfunction

  function automatic word_t sc_sat_add(input word_t acc, input word_t inc);
    logic [32:0] sum;
    sum = {1'b0, acc} + {1'b0, inc};
    return sum[32] ? 32'hFFFF_FFFF : sum[31:0];
  endfunction

endpackage

// File: rtl/sc_scratchpad_rd_pipe.sv
// sc_scratchpad_rd_pipe
//   RD_LAT-deep delay line for one read lane. Carries the valid strobe and the
//   x/w read data; data stages only load when a valid word passes through, so
//   the output data holds its last value while out_valid is low.
//   Ports:
//     clk       : clock
//     n_rst     : synchronous reset, active-high; flushes all stages to 0
//     in_valid  : read accepted this cycle
//     in_x/in_w : data sampled from storage this cycle
//     out_valid : strobe RD_LAT cycles after in_valid
//     out_x/w   : delayed data
module sc_scratchpad_rd_pipe
  import sc_scratchpad_pkg::*;
#(
  parameter int RD_LAT = 2
) (
  input  logic  clk,
  input  logic  n_rst,
  input  logic  in_valid,
  input  word_t in_x,
  input  word_t in_w,
  output logic  out_valid,
  output word_t out_x,
  output word_t out_w
);

  if (RD_LAT < 1 || RD_LAT > 4) begin : g_bad_lat
    $error("sc_scratchpad_rd_pipe: RD_LAT must be within 1..4");
  end

  logic [RD_LAT-1:0] vld_q;
  word_t             x_q [RD_LAT];
  word_t             w_q [RD_LAT];

  always_ff @(posedge clk) begin
    if (n_rst) begin
      vld_q <= '0;
      for (int i = 0; i < RD_LAT; i++) begin
        x_q[i] <= '0;
        w_q[i] <= '0;
      end
    end else begin
      vld_q[0] <= in_valid;
      if (in_valid) begin
        x_q[0] <= in_x;
        w_q[0] <= in_w;
      end
      for (int i = 1; i < RD_LAT; i++) begin
        vld_q[i] <= vld_q[i-1];
        if (vld_q[i-1]) begin
          x_q[i] <= x_q[i-1];
          w_q[i] <= w_q[i-1];
        end
      end
    end
  end

  assign out_valid = vld_q[RD_LAT-1];
  assign out_x     = x_q[RD_LAT-1];
  assign out_w     = w_q[RD_LAT-1];

endmodule

// File: rtl/sc_scratchpad.sv
// sc_scratchpad
//   Multi-lane scratchpad memory. N read lanes each fetch an x and a w word
//   and return them RD_LAT cycles later with a per-lane valid strobe; N write
//   lanes store output tiles. Out-of-range accesses are flagged (sticky, first
//   address captured) and in-range traffic is counted.
//   Ports:
//     clk, n_rst       : clock, synchronous active-high reset
//     sc_valid_queue   : per-lane read request
//     sc_x_queue/w     : per-lane x / w byte addresses
//     sc_valid_write   : per-lane write enable
//     sc_write_queue   : per-lane write byte address
//     sc_write_data    : per-lane write data
//     clr_stats        : clear counters and error capture
//     sc_x_data/w_data : read data, valid when sc_rd_valid is high
//     sc_rd_valid      : per-lane read strobe
//     err_oob/err_addr : sticky out-of-range flag and first offending address
//     rd_count/wr_count: saturating in-range read / write counters
module sc_scratchpad
  import sc_scratchpad_pkg::*;
#(
  parameter int          N           = 64,
  parameter int          DEPTH_WORDS = 4096,
  parameter logic [31:0] BASE_ADDR   = 32'h0,
  parameter int          RD_LAT      = 2
) (
  input  logic                clk,
  input  logic                n_rst,
  input  logic [N-1:0]        sc_valid_queue,
  input  logic [N-1:0][31:0]  sc_x_queue,
  input  logic [N-1:0][31:0]  sc_w_queue,
  input  logic [N-1:0]        sc_valid_write,
  input  logic [N-1:0][31:0]  sc_write_queue,
  input  logic [N-1:0][31:0]  sc_write_data,
  input  logic                clr_stats,
  output logic [N-1:0][31:0]  sc_x_data,
  output logic [N-1:0][31:0]  sc_w_data,
  output logic [N-1:0]        sc_rd_valid,
  output logic                err_oob,
  output logic [31:0]         err_addr,
  output logic [31:0]         rd_count,
  output logic [31:0]         wr_count
);

  localparam int    IDX_W = $clog2(DEPTH_WORDS);
  localparam word_t DEPTH = 32'(DEPTH_WORDS);

  function automatic logic [IDX_W-1:0] idx_of(input word_t addr);
    return IDX_W'((addr - BASE_ADDR) >> SC_WORD_SHIFT);
  endfunction

  word_t      mem [DEPTH_WORDS];

  sc_rd_req_t rd_req [N];
  sc_wr_req_t wr_req [N];

  logic [N-1:0] x_ok;
  logic [N-1:0] w_ok;
  logic [N-1:0] wr_ok;
  word_t        x_rd [N];
  word_t        w_rd [N];

  word_t rd_inc;
  word_t wr_inc;
  logic  err_hit;
  word_t err_hit_addr;

  // Request decode and storage read. Storage is read combinationally in the
  // request cycle, before that cycle's writes land, which gives
  // read-before-write on a same-word collision.
  always_comb begin
    for (int i = 0; i < N; i++) begin
      rd_req[i] = '{valid: sc_valid_queue[i], x_addr: sc_x_queue[i], w_addr: sc_w_queue[i]};
      wr_req[i] = '{valid: sc_valid_write[i], addr: sc_write_queue[i], data: sc_write_data[i]};
    end
    for (int i = 0; i < N; i++) begin
      x_ok[i]  = sc_in_range(rd_req[i].x_addr, BASE_ADDR, DEPTH);
      w_ok[i]  = sc_in_range(rd_req[i].w_addr, BASE_ADDR, DEPTH);
      wr_ok[i] = wr_req[i].valid && sc_in_range(wr_req[i].addr, BASE_ADDR, DEPTH);
      x_rd[i]  = x_ok[i] ? mem[idx_of(rd_req[i].x_addr)] : '0;
      w_rd[i]  = w_ok[i] ? mem[idx_of(rd_req[i].w_addr)] : '0;
    end
  end

  // Per-cycle counter increments and error selection. The error loop walks
  // from the highest lane down and, inside a lane, from lowest to highest
  // priority, so the last assignment is the winner.
  always_comb begin
    rd_inc       = '0;
    wr_inc       = '0;
    err_hit      = 1'b0;
    err_hit_addr = '0;
    for (int i = 0; i < N; i++) begin
      if (rd_req[i].valid && x_ok[i] && w_ok[i]) rd_inc = rd_inc + 32'd1;
      if (wr_ok[i]) wr_inc = wr_inc + 32'd1;
    end
    for (int i = N - 1; i >= 0; i--) begin
      if (wr_req[i].valid && !wr_ok[i]) begin
        err_hit      = 1'b1;
        err_hit_addr = wr_req[i].addr;
      end
      if (rd_req[i].valid && !w_ok[i]) begin
        err_hit      = 1'b1;
        err_hit_addr = rd_req[i].w_addr;
      end
      if (rd_req[i].valid && !x_ok[i]) begin
        err_hit      = 1'b1;
        err_hit_addr = rd_req[i].x_addr;
      end
    end
  end

  // Storage is never reset. Later lanes overwrite earlier ones, so the
  // highest lane wins a same-word write collision.
  always_ff @(posedge clk) begin
    if (!n_rst) begin
      for (int i = 0; i < N; i++) begin
        if (wr_ok[i]) mem[idx_of(wr_req[i].addr)] <= wr_req[i].data;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (n_rst || clr_stats) begin
      err_oob  <= 1'b0;
      err_addr <= '0;
      rd_count <= '0;
      wr_count <= '0;
    end else begin
      rd_count <= sc_sat_add(rd_count, rd_inc);
      wr_count <= sc_sat_add(wr_count, wr_inc);
      if (err_hit && !err_oob) begin
        err_oob  <= 1'b1;
        err_addr <= err_hit_addr;
      end
    end
  end

  for (genvar g = 0; g < N; g++) begin : g_lane
    sc_scratchpad_rd_pipe #(
      .RD_LAT (RD_LAT)
    ) u_rd_pipe (
      .clk       (clk),
      .n_rst     (n_rst),
      .in_valid  (rd_req[g].valid),
      .in_x      (x_rd[g]),
      .in_w      (w_rd[g]),
      .out_valid (sc_rd_valid[g]),
      .out_x     (sc_x_data[g]),
      .out_w     (sc_w_data[g])
    );
  end

endmodule

// File: tb/tb_sc_scratchpad.sv
// tb_sc_scratchpad
//   Directed bench for sc_scratchpad at its default parameters
//   (N=64, DEPTH_WORDS=4096, BASE_ADDR=0, RD_LAT=2).
module tb_sc_scratchpad;

  localparam int N = 64;

  logic                clk = 1'b0;
  logic                n_rst;
  logic [N-1:0]        sc_valid_queue;
  logic [N-1:0][31:0]  sc_x_queue;
  logic [N-1:0][31:0]  sc_w_queue;
  logic [N-1:0]        sc_valid_write;
  logic [N-1:0][31:0]  sc_write_queue;
  logic [N-1:0][31:0]  sc_write_data;
  logic                clr_stats;
  logic [N-1:0][31:0]  sc_x_data;
  logic [N-1:0][31:0]  sc_w_data;
  logic [N-1:0]        sc_rd_valid;
  logic                err_oob;
  logic [31:0]         err_addr;
  logic [31:0]         rd_count;
  logic [31:0]         wr_count;

  int checks   = 0;
  int failures = 0;

  sc_scratchpad u_dut (
    .clk            (clk),
    .n_rst          (n_rst),
    .sc_valid_queue (sc_valid_queue),
    .sc_x_queue     (sc_x_queue),
    .sc_w_queue     (sc_w_queue),
    .sc_valid_write (sc_valid_write),
    .sc_write_queue (sc_write_queue),
    .sc_write_data  (sc_write_data),
    .clr_stats      (clr_stats),
    .sc_x_data      (sc_x_data),
    .sc_w_data      (sc_w_data),
    .sc_rd_valid    (sc_rd_valid),
    .err_oob        (err_oob),
    .err_addr       (err_addr),
    .rd_count       (rd_count),
    .wr_count       (wr_count)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    sc_valid_queue = '0;
    sc_x_queue     = '0;
    sc_w_queue     = '0;
    sc_valid_write = '0;
    sc_write_queue = '0;
    sc_write_data  = '0;
    clr_stats      = 1'b0;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  int vld_total;
  int full_cycles;

  initial begin
    clear_inputs();
    n_rst = 1'b1;
    tick(); tick(); tick();

    check("rst_rd_valid", 64'(sc_rd_valid), 64'h0);
    check("rst_x_data0", 64'(sc_x_data[0]), 64'h0);
    check("rst_err_oob", 64'(err_oob), 64'h0);
    check("rst_err_addr", 64'(err_addr), 64'h0);
    check("rst_rd_count", 64'(rd_count), 64'h0);
    check("rst_wr_count", 64'(wr_count), 64'h0);
    n_rst = 1'b0;
    tick();

    // Write then read back on another lane.
    sc_valid_write[0] = 1'b1; sc_write_queue[0] = 32'h10; sc_write_data[0] = 32'hDEAD_BEEF;
    tick();
    clear_inputs();
    sc_valid_queue[5] = 1'b1; sc_x_queue[5] = 32'h10; sc_w_queue[5] = 32'h10;
    tick();
    clear_inputs();
    check("lat_not_early", 64'(sc_rd_valid), 64'h0);
    tick();
    check("basic_valid", 64'(sc_rd_valid), 64'h20);
    check("basic_x", 64'(sc_x_data[5]), 64'hDEAD_BEEF);
    check("basic_w", 64'(sc_w_data[5]), 64'hDEAD_BEEF);
    check("basic_wr_count", 64'(wr_count), 64'd1);
    check("basic_rd_count", 64'(rd_count), 64'd1);
    tick();
    check("hold_valid_low", 64'(sc_rd_valid), 64'h0);
    check("hold_x", 64'(sc_x_data[5]), 64'hDEAD_BEEF);

    // Read-before-write collision.
    sc_valid_write[0] = 1'b1; sc_write_queue[0] = 32'h20; sc_write_data[0] = 32'h5555;
    tick();
    clear_inputs();
    sc_valid_write[0] = 1'b1; sc_write_queue[0] = 32'h20; sc_write_data[0] = 32'h1234;
    sc_valid_queue[1] = 1'b1; sc_x_queue[1] = 32'h20; sc_w_queue[1] = 32'h10;
    tick();
    clear_inputs();
    sc_valid_queue[1] = 1'b1; sc_x_queue[1] = 32'h20; sc_w_queue[1] = 32'h10;
    tick();
    clear_inputs();
    check("rbw_valid", 64'(sc_rd_valid), 64'h2);
    check("rbw_old_data", 64'(sc_x_data[1]), 64'h5555);
    tick();
    check("rbw_valid2", 64'(sc_rd_valid), 64'h2);
    check("rbw_new_data", 64'(sc_x_data[1]), 64'h1234);
    check("rbw_wr_count", 64'(wr_count), 64'd3);
    check("rbw_rd_count", 64'(rd_count), 64'd3);

    // Multi-lane write collision: highest lane wins.
    sc_valid_write[2] = 1'b1; sc_write_queue[2] = 32'h30; sc_write_data[2] = 32'hAAAA;
    sc_valid_write[7] = 1'b1; sc_write_queue[7] = 32'h30; sc_write_data[7] = 32'hBBBB;
    tick();
    clear_inputs();
    sc_valid_queue[0] = 1'b1; sc_x_queue[0] = 32'h30; sc_w_queue[0] = 32'h30;
    tick();
    clear_inputs();
    tick();
    check("wcol_valid", 64'(sc_rd_valid), 64'h1);
    check("wcol_x", 64'(sc_x_data[0]), 64'hBBBB);
    check("wcol_wr_count", 64'(wr_count), 64'd5);
    check("wcol_rd_count", 64'(rd_count), 64'd4);

    // Out-of-range x read.
    sc_valid_queue[3] = 1'b1; sc_x_queue[3] = 32'h4000; sc_w_queue[3] = 32'h10;
    tick();
    clear_inputs();
    tick();
    check("oob_valid", 64'(sc_rd_valid), 64'h8);
    check("oob_x_zero", 64'(sc_x_data[3]), 64'h0);
    check("oob_w_data", 64'(sc_w_data[3]), 64'hDEAD_BEEF);
    check("oob_flag", 64'(err_oob), 64'h1);
    check("oob_addr", 64'(err_addr), 64'h4000);
    check("oob_rd_count", 64'(rd_count), 64'd4);

    // Second error (dropped write) keeps the first address.
    sc_valid_write[0] = 1'b1; sc_write_queue[0] = 32'h8000; sc_write_data[0] = 32'h1;
    tick();
    clear_inputs();
    check("oob2_addr_kept", 64'(err_addr), 64'h4000);
    check("oob2_wr_count", 64'(wr_count), 64'd5);

    clr_stats = 1'b1;
    tick();
    clear_inputs();
    check("clr_err_oob", 64'(err_oob), 64'h0);
    check("clr_err_addr", 64'(err_addr), 64'h0);
    check("clr_rd_count", 64'(rd_count), 64'h0);
    check("clr_wr_count", 64'(wr_count), 64'h0);

    // Error priority: lane 2 beats lane 6; within lane 2, w beats write.
    sc_valid_queue[6] = 1'b1; sc_x_queue[6] = 32'h7000; sc_w_queue[6] = 32'h10;
    sc_valid_queue[2] = 1'b1; sc_x_queue[2] = 32'h10;   sc_w_queue[2] = 32'h6004;
    sc_valid_write[2] = 1'b1; sc_write_queue[2] = 32'hA000; sc_write_data[2] = 32'h9;
    tick();
    clear_inputs();
    check("prio_flag", 64'(err_oob), 64'h1);
    check("prio_addr", 64'(err_addr), 64'h6004);
    check("prio_rd_count", 64'(rd_count), 64'h0);
    check("prio_wr_count", 64'(wr_count), 64'h0);

    // Clear wins over a same-cycle error.
    clr_stats = 1'b1;
    sc_valid_write[0] = 1'b1; sc_write_queue[0] = 32'hB000; sc_write_data[0] = 32'h2;
    tick();
    clear_inputs();
    check("clr_wins_flag", 64'(err_oob), 64'h0);
    check("clr_wins_addr", 64'(err_addr), 64'h0);
    tick(); tick();

    // Full-width back-to-back reads for 100 cycles.
    sc_valid_queue = '1;
    for (int i = 0; i < N; i++) begin
      sc_x_queue[i] = 32'h10;
      sc_w_queue[i] = 32'h30;
    end
    vld_total   = 0;
    full_cycles = 0;
    for (int c = 0; c < 102; c++) begin
      tick();
      if (c == 99) clear_inputs();
      vld_total += $countones(sc_rd_valid);
      if (&sc_rd_valid) full_cycles++;
    end
    check("tput_strobes", 64'(vld_total), 64'd6400);
    check("tput_full_cycles", 64'(full_cycles), 64'd100);
    check("tput_rd_count", 64'(rd_count), 64'd6400);
    check("tput_x63", 64'(sc_x_data[63]), 64'hDEAD_BEEF);
    check("tput_w0", 64'(sc_w_data[0]), 64'hBBBB);

    // Reset while a read is in flight.
    sc_valid_queue[9] = 1'b1; sc_x_queue[9] = 32'h10; sc_w_queue[9] = 32'h10;
    tick();
    clear_inputs();
    n_rst = 1'b1;
    tick();
    check("mrst_valid", 64'(sc_rd_valid), 64'h0);
    check("mrst_x9", 64'(sc_x_data[9]), 64'h0);
    check("mrst_w0", 64'(sc_w_data[0]), 64'h0);
    check("mrst_rd_count", 64'(rd_count), 64'h0);
    n_rst = 1'b0;
    sc_valid_queue[9] = 1'b1; sc_x_queue[9] = 32'h20; sc_w_queue[9] = 32'h30;
    tick();
    clear_inputs();
    check("mrst_no_stale", 64'(sc_rd_valid), 64'h0);
    tick();
    check("post_rst_valid", 64'(sc_rd_valid), 64'h200);
    check("post_rst_x", 64'(sc_x_data[9]), 64'h1234);
    check("post_rst_w", 64'(sc_w_data[9]), 64'hBBBB);
    check("post_rst_rd_count", 64'(rd_count), 64'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
